// File: rtl/vga_pixel_queue.sv
// vga_pixel_queue: pixel-bus capture FIFO draining into the VGA plot port.
// Optional input clipping of off-screen pixels under `PIXEL_CLIP_EN.
module vga_pixel_queue #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               bus_x,
    input  logic [7:0]               bus_y,
    input  logic [23:0]              bus_rgb,
    input  logic                     bus_draw_en,
    output logic                     bus_ready,
    output logic [7:0]               vga_x,
    output logic [7:0]               vga_y,
    output logic [23:0]              vga_colour,
    output logic                     vga_plot,
    input  logic                     vga_stall,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE, S_PLOT} state_t;

    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
        $error("screen dimensions must be positive");
    end

    logic [39:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    state_t       state;
    state_t       next_state;
    logic         in_range;
    logic         want;
    logic         full;
    logic         pop;
    logic         push;

`ifdef PIXEL_CLIP_EN
    assign in_range = (int'(bus_x) < SCREEN_W) && (int'(bus_y) < SCREEN_H);
`else
    assign in_range = 1'b1;
`endif

    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == LW'(DEPTH));
    assign bus_ready = (level <= LW'(DEPTH - 2));
    assign want      = (bus_draw_en == 1'b1) && in_range;
    assign pop       = (level != '0) && !vga_stall;
    // A full queue still accepts a write when the head leaves this cycle.
    assign push      = want && (!full || pop);
    assign vga_plot  = (state == S_PLOT);

    // Output FSM state register; reset drops the plot strobe at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next state: every popped pixel produces exactly one plot cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  next_state = pop ? S_PLOT : S_IDLE;
            S_PLOT:  next_state = pop ? S_PLOT : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Storage array; contents need no reset since pointers guard them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus_x, bus_y, bus_rgb};
    end

    // Pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Registered pixel towards the adapter, loaded only on a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else if (pop) begin
            {vga_x, vga_y, vga_colour} <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Sticky drop flag for writes lost against a full queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      overflow <= 1'b0;
        else if (want && full && !pop)  overflow <= 1'b1;
    end

endmodule

// File: tb/tb_vga_pixel_queue.sv
// tb_vga_pixel_queue: randomized and directed checks of vga_pixel_queue
// against a queue-based reference model.
module tb_vga_pixel_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bus_x = '0;
    logic [7:0]  bus_y = '0;
    logic [23:0] bus_rgb = '0;
    logic        bus_draw_en = 1'b0;
    logic        bus_ready;
    logic [7:0]  vga_x;
    logic [7:0]  vga_y;
    logic [23:0] vga_colour;
    logic        vga_plot;
    logic        vga_stall = 1'b0;
    logic [4:0]  level;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int plot_total = 0;

    logic [39:0] q[$];
    logic        plot_m = 1'b0;
    logic [39:0] exp_pix = '0;
    logic        ovf_m = 1'b0;

    vga_pixel_queue #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .reset(reset),
        .bus_x(bus_x), .bus_y(bus_y), .bus_rgb(bus_rgb),
        .bus_draw_en(bus_draw_en), .bus_ready(bus_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .vga_stall(vga_stall),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic bit visible(input logic [7:0] x, input logic [7:0] y);
`ifdef PIXEL_CLIP_EN
        return (x < 160) && (y < 120);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a plain queue, popped before pushed each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            plot_m  = 1'b0;
            exp_pix = '0;
            ovf_m   = 1'b0;
        end else begin
            int  sz;
            bit  p;
            sz = q.size();
            p  = (sz > 0) && !vga_stall;
            plot_m = p;
            if (p) exp_pix = q.pop_front();
            if (bus_draw_en && visible(bus_x, bus_y)) begin
                if (sz < DEPTH || p) q.push_back({bus_x, bus_y, bus_rgb});
                else ovf_m = 1'b1;
            end
        end
    end

    // Compare process: DUT against model every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("plot", vga_plot, plot_m);
            if (plot_m) begin
                plot_total++;
                check("pixel", {vga_x, vga_y, vga_colour}, exp_pix);
            end
            check("level", level, q.size());
            check("overflow", overflow, ovf_m);
            check("ready", bus_ready, q.size() <= DEPTH - 2);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
        bus_x = x; bus_y = y; bus_rgb = c; bus_draw_en = 1'b1;
        tick();
        bus_draw_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        bus_draw_en = 1'b0;
        vga_stall = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int base;
        tick();
        check("rst_plot", vga_plot, 0);
        check("rst_level", level, 0);
        check("rst_ready", bus_ready, 1);
        check("rst_ovf", overflow, 0);
        check("rst_pix", {vga_x, vga_y, vga_colour}, 0);
        reset = 1'b0;
        tick();

        // single pixel
        wr(8'd3, 8'd7, 24'hFF0000);
        tick();
        check("single_plot", vga_plot, 1);
        check("single_pix", {vga_x, vga_y, vga_colour}, {8'd3, 8'd7, 24'hFF0000});
        tick();
        check("single_end", vga_plot, 0);

        // streaming
        base = plot_total;
        for (int i = 0; i < 40; i++) begin
            bus_x = 8'(i); bus_y = 8'(i * 3); bus_rgb = 24'($urandom);
            bus_draw_en = 1'b1;
            tick();
            check("stream_lvl", level <= 1, 1);
        end
        drain(4);
        check("stream_cnt", plot_total - base, 40);
        check("stream_ovf", overflow, 0);

        // full push+pop
        vga_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr(8'(i), 8'(i), 24'($urandom));
            if (i == 13) check("ready_14", bus_ready, 1);
            if (i == 14) check("ready_15", bus_ready, 0);
        end
        check("full_lvl", level, 16);
        vga_stall = 1'b0;
        wr(8'd77, 8'd66, 24'h123456);
        check("fpp_lvl", level, 16);
        check("fpp_ovf", overflow, 0);
        drain(20);

        // reset mid-stream
        vga_stall = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'(i), 8'd1, 24'hABCDEF);
        vga_stall = 1'b0;
        tick();
        check("pre_rst_lvl", level, 5);
        check("pre_rst_plot", vga_plot, 1);
        #2 reset = 1'b1;
        #1;
        check("async_plot", vga_plot, 0);
        check("async_lvl", level, 0);
        check("async_pix", {vga_x, vga_y, vga_colour}, 0);
        tick();
        reset = 1'b0;
        base = plot_total;
        repeat (6) tick();
        check("post_rst_cnt", plot_total - base, 0);

        // fill and stall with drops
        vga_stall = 1'b1;
        for (int i = 0; i < 18; i++) wr(8'(i + 20), 8'd9, 24'($urandom));
        check("fill_lvl", level, 16);
        check("fill_ovf", overflow, 1);
        base = plot_total;
        drain(24);
        check("fill_cnt", plot_total - base, 16);
        do_reset();

        // clipping
        base = plot_total;
        wr(8'd159, 8'd119, 24'h000001);
        wr(8'd160, 8'd0, 24'h000002);
        wr(8'd0, 8'd120, 24'h000003);
        wr(8'd255, 8'd255, 24'h000004);
        drain(8);
`ifdef PIXEL_CLIP_EN
        check("clip_cnt", plot_total - base, 1);
`else
        check("clip_cnt", plot_total - base, 4);
`endif
        check("clip_ovf", overflow, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus_x = 8'($urandom);
            bus_y = 8'($urandom);
            bus_rgb = 24'($urandom);
            bus_draw_en = ($urandom_range(0, 3) != 0) &&
                          (bus_ready || ($urandom_range(0, 7) == 0));
            vga_stall = ($urandom_range(0, 9) < ((i / 500) % 2 ? 7 : 2));
            if (i == 1500) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end
        drain(24);
        check("end_lvl", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pixel_queue.md
# vga_pixel_queue

Downstream stage for the shared pixel bus driven by the screen-refresh and tile-drawing blocks. It captures every pixel-write presented on the bus (x, y, RGB, draw-enable) into a small FIFO. It optionally clips off-screen coordinates. It then drains the FIFO into the VGA adapter's plot port, one pixel per cycle, honouring a stall input from the adapter side.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `SCREEN_W`, 160: visible width; x ≥ SCREEN_W is off-screen.
- `SCREEN_H`, 120: visible height; y ≥ SCREEN_H is off-screen.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `bus_x` in 8: pixel x from shared bus.
- `bus_y` in 8: pixel y from shared bus.
- `bus_rgb` in 24: pixel colour from shared bus.
- `bus_draw_en` in 1: pixel-write strobe, one pixel per cycle high.
- `bus_ready` out 1: queue can absorb ≥ 2 more pixels; drawers pause while low.
- `vga_x` out 8: registered x to VGA adapter.
- `vga_y` out 8: registered y to VGA adapter.
- `vga_colour` out 24: registered colour to VGA adapter.
- `vga_plot` out 1: one-cycle plot strobe per pixel.
- `vga_stall` in 1: adapter cannot take a pixel this cycle.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a pixel was dropped because the queue was full.

## Operation
- **Enqueue:** at a rising edge where `bus_draw_en`=1, the pixel is not clipped, and the queue is not full, {x,y,rgb} is written at the write pointer and the write pointer advances.
- **Full write:** a write arriving while full, with no pop in the same cycle, is discarded and `overflow` is set. `overflow` clears only on `reset`.
- **Bus release:** a tri-stated bus reads as `bus_draw_en`≠1 and is ignored. The top level pulls `bus_draw_en` low when no drawer is active.
- **Output FSM, two states:**
  - S_IDLE: `vga_plot`=0. If the queue is non-empty and `vga_stall`=0, pop the head into `vga_x/y/colour`, set `vga_plot`=1, and go to S_PLOT.
  - S_PLOT: if the queue is non-empty and `vga_stall`=0, pop again, keep `vga_plot`=1, and stay. Otherwise `vga_plot`=0 and go to S_IDLE.
- **Plot/stall rule:** `vga_plot` is high exactly one cycle per popped pixel. `vga_stall` is sampled only at the pop decision; an already-registered pixel is never held or repeated.
- **Simultaneous push and pop:** both occur.
  - When full, the incoming write is accepted and `level` is unchanged.
  - When empty, there is no bypass: the pushed pixel pops on the following edge at the earliest.
- **Ordering:** pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit. Output order equals accepted input order.
- **`bus_ready`:** combinational, = (`level` ≤ DEPTH−2).

## Timing
- **Reset values:** `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0, `level`=0, `overflow`=0, `bus_ready`=1. Pointers are 0 and the FSM is in S_IDLE.
- **Latency:** a pixel accepted at edge N appears on `vga_*` with `vga_plot`=1 after edge N+1 at the earliest.
- **Throughput:** one pixel per cycle sustained with `vga_stall`=0; `level` then stays constant.
- **`level`:** updates on the same edge as the push/pop it reflects.
- **Reset mid-operation:** all queued pixels are lost. `vga_plot` drops asynchronously and no partial pixel is emitted after `reset` deasserts.

## Configuration
- **`PIXEL_CLIP_EN` defined:** a pixel with `bus_x` ≥ SCREEN_W or `bus_y` ≥ SCREEN_H is discarded at input. It is not enqueued and does not set `overflow`. This allows full-range 256×256 sweeps from the refresh block.
- **`PIXEL_CLIP_EN` undefined:** every strobed pixel is enqueued unchanged, and SCREEN_W/SCREEN_H are unused.

## Test plan
1. **Reset:** assert `reset` mid-stream with `level`=5. Outputs go to reset values immediately; after release, no `vga_plot` occurs until a new write.
2. **Single pixel:** write (3,7,0xFF0000) at edge N. `vga_plot`=1 with `vga_x`=3, `vga_y`=7, `vga_colour`=0xFF0000 after edge N+1, then `vga_plot`=0.
3. **Streaming:** 40 consecutive writes with `vga_stall`=0. Exactly 40 plot cycles occur, in order, back-to-back; `level` ≤ 1 and `overflow`=0.
4. **Fill and stall:** `vga_stall`=1 with 18 writes at DEPTH=16.
   - `bus_ready` falls when `level` reaches 15.
   - The first 16 pixels are stored; pixels 17 and 18 are dropped; `overflow`=1.
   - After releasing the stall, exactly 16 plots occur.
5. **Full push+pop:** `level`=16, `vga_stall`=0, write in the same cycle. The write is accepted, `level` stays 16, and `overflow` stays 0.
6. **Clip (`PIXEL_CLIP_EN`):** write (159,119), (160,0), (0,120), (255,255). Only (159,119) is plotted and `overflow`=0. Without the macro, all four are plotted.
